// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator display controller.
package calc_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SLOT_W     = 3;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [DIGIT_W-1:0] POS_EOF = 4'd8;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ERROR   = 2'd2
  } disp_state_t;

endpackage

// File: rtl/calc_display_ctrl_seg7_decoder.sv
// BCD value to active-low seven-segment glyph; values 10-15 render blank.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [6:0]         seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (value)
      4'd0:    seg_c = 7'h40;
      4'd1:    seg_c = 7'h79;
      4'd2:    seg_c = 7'h24;
      4'd3:    seg_c = 7'h30;
      4'd4:    seg_c = 7'h19;
      4'd5:    seg_c = 7'h12;
      4'd6:    seg_c = 7'h02;
      4'd7:    seg_c = 7'h78;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h10;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_ctrl.sv
// Receives digit-print writes from the calculator core, commits whole frames
// atomically and scans them onto eight multiplexed seven-segment displays.
module calc_display_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         status,
  input  logic [DIGIT_W-1:0] data,
  input  logic [DIGIT_W-1:0] pos,
  output logic [7:0]         an,
  output logic [7:0]         seg,
  output logic               frame_ok
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  disp_state_t        state_q, state_d;
  logic               shadow_clr, shadow_wr, commit;
  logic [DIGIT_W-1:0] shadow_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] disp_q   [NUM_DIGITS];
  logic [DIV_W-1:0]   div_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [SLOT_W-1:0]  hi_slot;
  logic [DIGIT_W-1:0] cur_digit;
  logic [6:0]         dec_seg;
  logic [6:0]         glyph;
  logic               dp_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Error has priority over everything and never clears on its own
  always_comb begin
    state_d    = state_q;
    shadow_clr = 1'b0;
    shadow_wr  = 1'b0;
    commit     = 1'b0;
    if (status == ST_ERRO) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE: begin
          if (status == ST_PRINT) begin
            state_d    = CAPTURE;
            shadow_clr = 1'b1;
            shadow_wr  = (pos < POS_EOF);
          end
        end
        CAPTURE: begin
          if (status == ST_PRINT) begin
            if (pos < POS_EOF) begin
              shadow_wr = 1'b1;
            end else if (pos == POS_EOF) begin
              commit  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = ERROR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (shadow_clr) shadow_q[i] <= '0;
        if (shadow_wr && (pos[SLOT_W-1:0] == SLOT_W'(i))) shadow_q[i] <= data;
      end
      if (commit) disp_q <= shadow_q;
    end
  end

  // Refresh divider and scan slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      slot_q <= '0;
    end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_q  <= '0;
      slot_q <= slot_q + SLOT_W'(1);
    end else begin
      div_q  <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    hi_slot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_q[i] != '0) hi_slot = SLOT_W'(i);
    end
  end

  assign cur_digit = disp_q[slot_q];

  seg7_decoder u_dec (
    .value (cur_digit),
    .seg_c (dec_seg)
  );

  // Slot 0 is never blanked so an empty buffer still reads "0"
  always_comb begin
    glyph = SEG_BLANK;
    dp_n  = 1'b1;
    if (state_q == ERROR) begin
      case (slot_q)
        3'd3:       glyph = SEG_E;
        3'd2, 3'd1: glyph = SEG_R;
        3'd0:       glyph = SEG_O;
        default:    glyph = SEG_BLANK;
      endcase
    end else begin
      if ((slot_q == '0) || (slot_q <= hi_slot)) glyph = dec_seg;
      dp_n = !((slot_q == '0) && (status == ST_BUSY));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an       <= 8'hFF;
      seg      <= 8'hFF;
      frame_ok <= 1'b0;
    end else begin
      an       <= ~(8'b1 << slot_q);
      seg      <= {dp_n, glyph};
      frame_ok <= commit;
    end
  end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Self-checking bench for calc_display_ctrl: directed frame tables plus
// randomized traffic against a frame-level reference model.
module tb_calc_display_ctrl;

  localparam int unsigned DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an, seg;
  logic       frame_ok;

  calc_display_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .status   (status),
    .data     (data),
    .pos      (pos),
    .an       (an),
    .seg      (seg),
    .frame_ok (frame_ok)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_disp   [8];
  logic [3:0] m_shadow [8];
  bit         m_err;
  bit         m_frame;
  int         n_edges;
  logic [7:0] seen [8];
  logic [7:0] glyph_tbl [10];

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  d;
    logic [3:0]  p;
    logic        fok;
    bit          show;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_glyph(input int s, input logic [1:0] st);
    int         h;
    logic [7:0] g;
    h = 0;
    if (m_err) begin
      case (s)
        3:       return 8'h86;
        2, 1:    return 8'hAF;
        0:       return 8'hA3;
        default: return 8'hFF;
      endcase
    end
    for (int i = 0; i < 8; i++) if (m_disp[i] != 4'd0) h = i;
    g = 8'hFF;
    if (s == 0 || s <= h) g = (m_disp[s] < 4'd10) ? glyph_tbl[m_disp[s]] : 8'hFF;
    if (s == 0 && st == 2'b01) g[7] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_disp[i]   = 4'd0;
      m_shadow[i] = 4'd0;
    end
    m_err   = 1'b0;
    m_frame = 1'b0;
    n_edges = 0;
  endtask

  // One clock: apply inputs, advance the model, check every output
  task automatic step(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
    int         s;
    logic [7:0] eg, ean;
    logic       efok;
    status = st;
    data   = d;
    pos    = p;
    s      = (n_edges / DIV) % 8;
    eg     = exp_glyph(s, st);
    ean    = ~(8'd1 << s);
    efok   = 1'b0;
    if (!m_err) begin
      if (st == 2'b00) begin
        m_err   = 1'b1;
        m_frame = 1'b0;
      end else if (!m_frame) begin
        if (st == 2'b11) begin
          for (int i = 0; i < 8; i++) m_shadow[i] = 4'd0;
          m_frame = 1'b1;
          if (p < 4'd8) m_shadow[p[2:0]] = d;
        end
      end else if (st == 2'b11) begin
        if (p < 4'd8) m_shadow[p[2:0]] = d;
        else if (p == 4'd8) begin
          m_disp  = m_shadow;
          efok    = 1'b1;
          m_frame = 1'b0;
        end
      end else begin
        m_frame = 1'b0;
      end
    end
    @(posedge clock);
    n_edges++;
    #1;
    check8("an", an, ean);
    check8("seg", seg, eg);
    check8("frame_ok", {7'd0, frame_ok}, {7'd0, efok});
    seen[s] = seg;
  endtask

  // Hold status for a full scan round and compare each slot to constants
  task automatic show(input string name, input logic [1:0] st, input logic [63:0] exp);
    for (int k = 0; k < 8 * DIV + 4; k++) step(st, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) check8(name, seen[i], exp[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check8("rst_an", an, 8'hFF);
    check8("rst_seg", seg, 8'hFF);
    check8("rst_fok", {7'd0, frame_ok}, 8'd0);
    model_reset();
    @(posedge clock);
    #1;
    status = 2'b10;
    reset  = 1'b1;
  endtask

  initial begin
    logic [1:0] st;
    int         r;
    glyph_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    model_reset();
    #2;
    do_reset();

    show("reset_view", 2'b10, 64'hFFFF_FFFF_FFFF_FFC0);

    vt.push_back('{2'b11, 4'd3, 4'd0, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd2, 4'd1, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd1, 4'd2, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd0, 4'd8, 1'b1, 1'b0, 64'd0});
    vt.push_back('{2'b10, 4'd0, 4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFF9_A4B0});
    vt.push_back('{2'b11, 4'd9, 4'd0, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b10, 4'd0, 4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFF9_A4B0});
    vt.push_back('{2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFF9_A430});
    vt.push_back('{2'b11, 4'd5, 4'd0, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd6, 4'd9, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd7, 4'd0, 1'b0, 1'b0, 64'd0});
    vt.push_back('{2'b11, 4'd0, 4'd8, 1'b1, 1'b0, 64'd0});
    vt.push_back('{2'b10, 4'd0, 4'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8});

    foreach (vt[k]) begin
      step(vt[k].st, vt[k].d, vt[k].p);
      check8("tbl_fok", {7'd0, frame_ok}, {7'd0, vt[k].fok});
      if (vt[k].show) show("tbl_view", vt[k].st, vt[k].exp);
    end

    for (int k = 0; k < 1500; k++) begin
      r  = int'($urandom_range(0, 99));
      st = (r < 85) ? 2'b11 : (r < 95) ? 2'b10 : 2'b01;
      step(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 10)));
    end

    // Error mid-frame is sticky and ignores later frames
    step(2'b11, 4'd4, 4'd0);
    step(2'b00, 4'd0, 4'd0);
    show("err_view", 2'b10, 64'hFFFF_FFFF_86AF_AFA3);
    step(2'b11, 4'd1, 4'd0);
    step(2'b11, 4'd0, 4'd8);
    check8("err_no_fok", {7'd0, frame_ok}, 8'd0);
    show("err_sticky", 2'b01, 64'hFFFF_FFFF_86AF_AFA3);
    do_reset();
    show("post_err_reset", 2'b10, 64'hFFFF_FFFF_FFFF_FFC0);

    // Error arriving with the end-of-frame marker blocks the commit
    step(2'b11, 4'd6, 4'd0);
    step(2'b00, 4'd0, 4'd8);
    step(2'b10, 4'd0, 4'd0);
    check8("err_eof_fok", {7'd0, frame_ok}, 8'd0);
    show("err_eof_view", 2'b10, 64'hFFFF_FFFF_86AF_AFA3);
    do_reset();
    show("final_reset", 2'b10, 64'hFFFF_FFFF_FFFF_FFC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
